axi_lite_subordinate_ram: RTL and testbench

AXI4-Lite subordinate (responder) backed by a word-addressed RAM. It is the far end of the SoC's AXI4-Lite manager port and serves the external memory window at 0x4000_0000. It is used in SoC benches and FPGA builds in place of off-chip memory. Write and read channels are independent; a wait-state counter on the read path models memory latency.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/sub_word_ram.sv | 27 ++
 rtl/axi_lite_subordinate_ram.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_subordinate_ram.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the channel FSM states
// used by the subordinate RAM and the AXI4-Lite manager.
package axi_lite_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_ADDR,
      W_HAVE_DATA,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } r_state_t;

   // Response code for an access that did or did not fall inside the window.
   function automatic logic [1:0] resp_for(input logic err);
      return err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/sub_word_ram.sv
// Simple dual-port word RAM: one synchronous write port, one synchronous
// read port, read-before-write on a same-address collision. Written in the
// read-first template so FPGA tools map it onto block RAM.
module sub_word_ram
   import axi_lite_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Both ports in one process so a colliding read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_lite_subordinate_ram.sv
// AXI4-Lite subordinate backed by a word RAM, serving the window starting at
// BASE_ADDR. Independent write and read FSMs; the read path inserts
// READ_LATENCY wait cycles. Define AXI_SUB_RAM_DECERR_EN to answer accesses
// outside the window with DECERR instead of wrapping.
module axi_lite_subordinate_ram
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   input  logic [31:0] ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY
);

   localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef AXI_SUB_RAM_DECERR_EN
   localparam bit DECERR_EN = 1'b1;
`else
   localparam bit DECERR_EN = 1'b0;
`endif

   // ---------------- write channel ----------------
   w_state_t    wstate;
   logic [31:0] aw_addr_q, w_data_q;
   logic [31:0] wr_addr, wr_data, wr_off;
   logic        aw_hs, w_hs, wr_commit, wr_err;

   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   // The half that arrived earlier comes from its latch, the other is live.
   assign wr_addr = (wstate == W_HAVE_ADDR) ? aw_addr_q : AWADDR;
   assign wr_data = (wstate == W_HAVE_DATA) ? w_data_q : WDATA;
   assign wr_off  = wr_addr - BASE_ADDR;
   assign wr_err  = DECERR_EN && (wr_off >= WINDOW_BYTES);
   assign wr_commit = ((wstate == W_IDLE) && aw_hs && w_hs) ||
                      ((wstate == W_HAVE_ADDR) && w_hs) ||
                      ((wstate == W_HAVE_DATA) && aw_hs);

   // Write FSM with registered ready/response outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wstate    <= W_IDLE;
         AWREADY   <= 1'b0;
         WREADY    <= 1'b0;
         BVALID    <= 1'b0;
         BRESP     <= AXI_RESP_OKAY;
         aw_addr_q <= '0;
         w_data_q  <= '0;
      end else begin
         if (wr_commit) begin
            wstate  <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= resp_for(wr_err);
         end else begin
            case (wstate)
               W_IDLE: begin
                  AWREADY <= 1'b1;
                  WREADY  <= 1'b1;
                  if (aw_hs) begin
                     aw_addr_q <= AWADDR;
                     wstate    <= W_HAVE_ADDR;
                     AWREADY   <= 1'b0;
                  end else if (w_hs) begin
                     w_data_q <= WDATA;
                     wstate   <= W_HAVE_DATA;
                     WREADY   <= 1'b0;
                  end
               end
               W_RESP: begin
                  if (BREADY) begin
                     wstate  <= W_IDLE;
                     BVALID  <= 1'b0;
                     BRESP   <= AXI_RESP_OKAY;
                     AWREADY <= 1'b1;
                     WREADY  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- read channel ----------------
   r_state_t          rstate;
   logic [IDX_W-1:0]  rd_idx_q;
   logic [3:0]        rd_cnt_q;
   logic              rd_err_q;
   logic [31:0]       ar_off, ram_rdata;
   logic              ram_re;

   assign ar_off = ARADDR - BASE_ADDR;
   assign ram_re = (rstate == R_WAIT) && (rd_cnt_q == '0);
   // RAM output register has no reset; gate it so RDATA is 0 outside R_DATA
   // and for decode errors.
   assign RDATA  = (RVALID && !rd_err_q) ? ram_rdata : '0;

   // Read FSM with latency counter and registered valid/response outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rstate   <= R_IDLE;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RRESP    <= AXI_RESP_OKAY;
         rd_idx_q <= '0;
         rd_cnt_q <= '0;
         rd_err_q <= 1'b0;
      end else begin
         case (rstate)
            R_IDLE: begin
               ARREADY <= 1'b1;
               if (ARVALID && ARREADY) begin
                  rd_idx_q <= ar_off[IDX_W+1:2];
                  rd_cnt_q <= 4'(READ_LATENCY);
                  rd_err_q <= DECERR_EN && (ar_off >= WINDOW_BYTES);
                  ARREADY  <= 1'b0;
                  rstate   <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (rd_cnt_q == '0) begin
                  rstate <= R_DATA;
                  RVALID <= 1'b1;
                  RRESP  <= resp_for(rd_err_q);
               end else begin
                  rd_cnt_q <= rd_cnt_q - 4'd1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  rstate  <= R_IDLE;
                  RVALID  <= 1'b0;
                  RRESP   <= AXI_RESP_OKAY;
                  ARREADY <= 1'b1;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   sub_word_ram #(
      .DEPTH (DEPTH_WORDS),
      .WIDTH (32)
   ) u_ram (
      .clk   (clk),
      .we    (wr_commit && !wr_err),
      .waddr (wr_off[IDX_W+1:2]),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (rd_idx_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_axi_lite_subordinate_ram.sv
// Directed bench for axi_lite_subordinate_ram. Two instances share all inputs:
// dut0 with READ_LATENCY=0 and dut3 with READ_LATENCY=3. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_axi_lite_subordinate_ram;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] awaddr, wdata, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;

   logic        awready0, wready0, bvalid0, arready0, rvalid0;
   logic [1:0]  bresp0, rresp0;
   logic [31:0] rdata0;
   logic        awready3, wready3, bvalid3, arready3, rvalid3;
   logic [1:0]  bresp3, rresp3;
   logic [31:0] rdata3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_lite_subordinate_ram #(
      .BASE_ADDR(32'h4000_0000), .DEPTH_WORDS(1024), .READ_LATENCY(0)
   ) dut0 (
      .clk(clk), .resetn(resetn),
      .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready0),
      .WDATA(wdata), .WVALID(wvalid), .WREADY(wready0),
      .BRESP(bresp0), .BVALID(bvalid0), .BREADY(bready),
      .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready0),
      .RDATA(rdata0), .RRESP(rresp0), .RVALID(rvalid0), .RREADY(rready)
   );

   axi_lite_subordinate_ram #(
      .BASE_ADDR(32'h4000_0000), .DEPTH_WORDS(1024), .READ_LATENCY(3)
   ) dut3 (
      .clk(clk), .resetn(resetn),
      .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready3),
      .WDATA(wdata), .WVALID(wvalid), .WREADY(wready3),
      .BRESP(bresp3), .BVALID(bvalid3), .BREADY(bready),
      .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready3),
      .RDATA(rdata3), .RRESP(rresp3), .RVALID(rvalid3), .RREADY(rready)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Write one word; mode 0 = AW and W together, 1 = W first, 2 = AW first.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input int mode,
                     input logic [1:0] exp_resp, input string nm);
      bready = 1'b1;
      if (mode == 0) begin
         awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1;
         tick(); awvalid = 1'b0; wvalid = 1'b0;
      end else if (mode == 1) begin
         wdata = d; wvalid = 1'b1; tick(); wvalid = 1'b0;
         n_tests++;
         if ({awready0, wready0, bvalid0} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s w_first_ready: aw/w/b=%b want 100", nm, {awready0, wready0, bvalid0});
         end
         awaddr = a; awvalid = 1'b1; tick(); awvalid = 1'b0;
      end else begin
         awaddr = a; awvalid = 1'b1; tick(); awvalid = 1'b0;
         n_tests++;
         if ({awready0, wready0, bvalid0} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s aw_first_ready: aw/w/b=%b want 010", nm, {awready0, wready0, bvalid0});
         end
         wdata = d; wvalid = 1'b1; tick(); wvalid = 1'b0;
      end
      n_tests++;
      if ({bvalid0, bresp0, bvalid3, bresp3, awready0, wready0} !== {1'b1, exp_resp, 1'b1, exp_resp, 2'b00}) begin
         n_fail++;
         $display("FAIL %s bresp: bv0=%b br0=%b bv3=%b br3=%b awr=%b wr=%b want bv=1 br=%b rdy=00",
                  nm, bvalid0, bresp0, bvalid3, bresp3, awready0, wready0, exp_resp);
      end
      tick();
      n_tests++;
      if ({bvalid0, awready0, wready0} !== 3'b011) begin
         n_fail++;
         $display("FAIL %s b_done: bv/awr/wr=%b want 011", nm, {bvalid0, awready0, wready0});
      end
   endtask

   // Read one word with RREADY high; checks data and latency on both instances.
   task automatic rd(input logic [31:0] a, input logic [31:0] exp_d,
                     input logic [1:0] exp_resp, input string nm);
      int lat0 = -1;
      int lat3 = -1;
      logic [31:0] d0 = '0, d3 = '0;
      logic [1:0]  r0 = '0, r3 = '0;
      rready = 1'b1; araddr = a; arvalid = 1'b1;
      tick(); arvalid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (rvalid0 === 1'b1 && lat0 < 0) begin lat0 = k; d0 = rdata0; r0 = rresp0; end
         if (rvalid3 === 1'b1 && lat3 < 0) begin lat3 = k; d3 = rdata3; r3 = rresp3; end
      end
      n_tests++;
      if (lat0 != 1 || lat3 != 4) begin
         n_fail++;
         $display("FAIL %s latency: lat0=%0d lat3=%0d want 1 and 4", nm, lat0, lat3);
      end
      n_tests++;
      if ({d0, r0, d3, r3} !== {exp_d, exp_resp, exp_d, exp_resp}) begin
         n_fail++;
         $display("FAIL %s rdata: d0=%h r0=%b d3=%h r3=%b want %h %b", nm, d0, r0, d3, r3, exp_d, exp_resp);
      end
      n_tests++;
      if ({rvalid0, rvalid3, arready0, arready3} !== 4'b0011) begin
         n_fail++;
         $display("FAIL %s r_done: rv0/rv3/arr0/arr3=%b want 0011", nm, {rvalid0, rvalid3, arready0, arready3});
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      awaddr = '0; wdata = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      tick(); tick();
      n_tests++;
      if ({awready0, wready0, arready0, bvalid0, rvalid0, bresp0, rresp0, rdata0,
           awready3, wready3, arready3, bvalid3, rvalid3, bresp3, rresp3, rdata3} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: dut0 rdy=%b%b%b v=%b%b dut3 rdy=%b%b%b v=%b%b want all 0",
                  awready0, wready0, arready0, bvalid0, rvalid0, awready3, wready3, arready3, bvalid3, rvalid3);
      end
      resetn = 1'b1;
      tick();
      n_tests++;
      if ({awready0, wready0, arready0, awready3, wready3, arready3} !== 6'b111111) begin
         n_fail++;
         $display("FAIL reset_release_ready: dut0=%b%b%b dut3=%b%b%b want 111 111",
                  awready0, wready0, arready0, awready3, wready3, arready3);
      end
   endtask

   task automatic test_write_same_cycle();
      wr(32'h4000_0010, 32'hDEAD_BEEF, 0, 2'b00, "same_cycle");
      rd(32'h4000_0010, 32'hDEAD_BEEF, 2'b00, "same_cycle_rd");
   endtask

   task automatic test_split_order();
      wr(32'h4000_0000, 32'h1111_1111, 1, 2'b00, "w_first");
      wr(32'h4000_0004, 32'h2222_2222, 2, 2'b00, "aw_first");
      rd(32'h4000_0000, 32'h1111_1111, 2'b00, "w_first_rd");
      rd(32'h4000_0004, 32'h2222_2222, 2'b00, "aw_first_rd");
      rd(32'h4000_0007, 32'h2222_2222, 2'b00, "low_bits_ignored");
   endtask

   task automatic test_backpressure();
      bready = 1'b0;
      awaddr = 32'h4000_0008; wdata = 32'h3333_3333; awvalid = 1'b1; wvalid = 1'b1;
      tick(); awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if ({bvalid0, bresp0, awready0, wready0} !== 5'b1_00_00) begin
            n_fail++;
            $display("FAIL b_stall[%0d]: bv=%b br=%b awr=%b wr=%b want 1 00 0 0", i, bvalid0, bresp0, awready0, wready0);
         end
      end
      bready = 1'b1; tick();
      n_tests++;
      if ({bvalid0, awready0} !== 2'b01) begin
         n_fail++;
         $display("FAIL b_release: bv/awr=%b want 01", {bvalid0, awready0});
      end
      rready = 1'b0; araddr = 32'h4000_0008; arvalid = 1'b1;
      tick(); arvalid = 1'b0; tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if ({rvalid0, rdata0, rresp0, arready0} !== {1'b1, 32'h3333_3333, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL r_stall[%0d]: rv=%b rd=%h rr=%b arr=%b want 1 33333333 00 0", i, rvalid0, rdata0, rresp0, arready0);
         end
      end
      n_tests++;
      if ({rvalid3, rdata3, arready3} !== {1'b1, 32'h3333_3333, 1'b0}) begin
         n_fail++;
         $display("FAIL r_stall_lat3: rv=%b rd=%h arr=%b want 1 33333333 0", rvalid3, rdata3, arready3);
      end
      rready = 1'b1; tick();
      n_tests++;
      if ({rvalid0, rvalid3, arready0, arready3} !== 4'b0011) begin
         n_fail++;
         $display("FAIL r_release: rv0/rv3/arr0/arr3=%b want 0011", {rvalid0, rvalid3, arready0, arready3});
      end
   endtask

   task automatic test_read_before_write();
      wr(32'h4000_0020, 32'h5A5A_5A5A, 0, 2'b00, "rbw_init");
      rready = 1'b1; bready = 1'b1;
      araddr = 32'h4000_0020; arvalid = 1'b1;
      tick(); arvalid = 1'b0;
      tick(); tick(); tick();
      n_tests++;
      if (rvalid3 !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_early: rvalid3=%b at N+3 want 0", rvalid3);
      end
      awaddr = 32'h4000_0020; wdata = 32'hA5A5_A5A5; awvalid = 1'b1; wvalid = 1'b1;
      tick(); awvalid = 1'b0; wvalid = 1'b0;
      n_tests++;
      if ({rvalid3, rdata3, bvalid0} !== {1'b1, 32'h5A5A_5A5A, 1'b1}) begin
         n_fail++;
         $display("FAIL rbw_old_data: rv3=%b rd3=%h bv=%b want 1 5a5a5a5a 1", rvalid3, rdata3, bvalid0);
      end
      tick();
      n_tests++;
      if ({rvalid3, bvalid0} !== 2'b00) begin
         n_fail++;
         $display("FAIL rbw_done: rv3/bv=%b want 00", {rvalid3, bvalid0});
      end
      rd(32'h4000_0020, 32'hA5A5_A5A5, 2'b00, "rbw_new_data");
   endtask

   task automatic test_wrap_range();
      wr(32'h4000_0FFC, 32'h0FFC_0FFC, 0, 2'b00, "last_word");
      rd(32'h4000_0FFC, 32'h0FFC_0FFC, 2'b00, "last_word_rd");
`ifdef AXI_SUB_RAM_DECERR_EN
      wr(32'h4000_1000, 32'hCAFE_F00D, 0, 2'b11, "oob_write");
      rd(32'h4000_0000, 32'h1111_1111, 2'b00, "word0_kept");
      rd(32'h3FFF_FFFC, 32'h0000_0000, 2'b11, "oob_read");
`else
      wr(32'h4000_1000, 32'hCAFE_F00D, 0, 2'b00, "wrap_write");
      rd(32'h4000_0000, 32'hCAFE_F00D, 2'b00, "wrap_read");
`endif
   endtask

   task automatic test_reset_mid();
      bready = 1'b0; rready = 1'b0;
      awaddr = 32'h4000_0030; awvalid = 1'b1; araddr = 32'h4000_0030; arvalid = 1'b1;
      tick(); awvalid = 1'b0; arvalid = 1'b0;
      n_tests++;
      if ({awready0, wready0, arready3, rvalid3} !== 4'b0100) begin
         n_fail++;
         $display("FAIL mid_state: awr/wr/arr3/rv3=%b want 0100", {awready0, wready0, arready3, rvalid3});
      end
      #2 resetn = 1'b0;
      #1;
      n_tests++;
      if ({awready0, wready0, arready0, bvalid0, rvalid0, awready3, wready3, arready3, bvalid3, rvalid3} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_zero: dut0=%b%b%b%b%b dut3=%b%b%b%b%b want all 0",
                  awready0, wready0, arready0, bvalid0, rvalid0, awready3, wready3, arready3, bvalid3, rvalid3);
      end
      tick(); tick();
      resetn = 1'b1;
      tick();
      n_tests++;
      if ({awready0, wready0, arready0, awready3, wready3, arready3} !== 6'b111111) begin
         n_fail++;
         $display("FAIL mid_release_ready: dut0=%b%b%b dut3=%b%b%b want 111 111",
                  awready0, wready0, arready0, awready3, wready3, arready3);
      end
      bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if ({bvalid0, rvalid0, bvalid3, rvalid3} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stale_resp[%0d]: bv0/rv0/bv3/rv3=%b want 0000", i, {bvalid0, rvalid0, bvalid3, rvalid3});
         end
      end
      rd(32'h4000_0020, 32'hA5A5_A5A5, 2'b00, "after_reset_rd");
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_split_order();
      test_backpressure();
      test_read_before_write();
      test_wrap_range();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in 200000 time units");
      $fatal(1);
   end

endmodule
